// File: rtl/fifo_wr_burst.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_burst
// Description : FIFO write-side burst controller with low/high watermark
//               hysteresis, incrementing data pattern and burst statistics.
//               Define FIFO_WR_OVF_CNT_EN to enable the dropped-write counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_burst #(
    parameter int DATA_W    = 16,
    parameter int USEDW_W   = 8,
    parameter int LOW_WM    = 8,
    parameter int HIGH_WM   = 240,
    parameter int MAX_BURST = 0,
    parameter int DATA_INIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              wrempty,
    input  logic              wrfull,
    input  logic [USEDW_W-1:0] wrusedw,
    output logic              wrreq,
    output logic [DATA_W-1:0] wrdata,
    output logic              busy,
    output logic              burst_done,
    output logic [15:0]       burst_cnt,
    output logic [15:0]       ovf_cnt
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ARM  = 2'd1;
    localparam logic [1:0] c_FILL = 2'd2;

    localparam int c_WCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;

    localparam logic [c_WCNT_W-1:0] c_MAX_BURST = c_WCNT_W'(MAX_BURST);
    localparam logic [USEDW_W-1:0]  c_LOW_WM    = USEDW_W'(LOW_WM);
    localparam logic [USEDW_W-1:0]  c_HIGH_WM   = USEDW_W'(HIGH_WM);
    localparam logic [DATA_W-1:0]   c_DATA_INIT = DATA_W'(DATA_INIT);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                w_start;
    logic                w_stop;
    logic                w_accept;
    logic                w_burst_lim;
    logic [c_WCNT_W-1:0] w_word_nxt;

    logic                r_wrreq;
    logic [DATA_W-1:0]   r_wrdata;
    logic                r_busy;
    logic                r_burst_done;
    logic [15:0]         r_burst_cnt;
    logic [c_WCNT_W-1:0] r_word_cnt;

    // A write is only consumed when the FIFO is not full in the same cycle
    assign w_accept    = r_wrreq && !wrfull;
    assign w_word_nxt  = r_word_cnt + c_WCNT_W'(w_accept);
    assign w_burst_lim = (MAX_BURST != 0) && (w_word_nxt >= c_MAX_BURST);

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_stop      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (en) w_state_nxt = c_ARM;
            end
            c_ARM: begin
                if (!en) begin
                    w_state_nxt = c_IDLE;
                end else if (wrempty || (wrusedw <= c_LOW_WM)) begin
                    w_state_nxt = c_FILL;
                    w_start     = 1'b1;
                end
            end
            c_FILL: begin
                // wrusedw may lag the FIFO; wrfull is the authoritative stop
                if (wrfull || (wrusedw >= c_HIGH_WM) || !en || w_burst_lim) begin
                    w_stop      = 1'b1;
                    w_state_nxt = en ? c_ARM : c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrreq      <= 1'b0;
            r_wrdata     <= c_DATA_INIT;
            r_busy       <= 1'b0;
            r_burst_done <= 1'b0;
            r_burst_cnt  <= 16'h0000;
            r_word_cnt   <= '0;
        end else begin
            r_burst_done <= w_stop;
            if (w_start) begin
                r_wrreq    <= 1'b1;
                r_busy     <= 1'b1;
                r_word_cnt <= '0;
            end else begin
                if (w_stop) begin
                    r_wrreq <= 1'b0;
                    r_busy  <= 1'b0;
                end
                if (w_accept) r_word_cnt <= w_word_nxt;
            end
            // clr wins over pattern advance and burst counting
            if (clr) begin
                r_wrdata    <= c_DATA_INIT;
                r_burst_cnt <= 16'h0000;
            end else begin
                if (w_accept) r_wrdata <= r_wrdata + 1'b1;
                if (w_stop)   r_burst_cnt <= r_burst_cnt + 16'h0001;
            end
        end
    end

`ifdef FIFO_WR_OVF_CNT_EN
    logic [15:0] r_ovf_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_cnt <= 16'h0000;
        end else if (clr) begin
            r_ovf_cnt <= 16'h0000;
        end else if (r_wrreq && wrfull && (r_ovf_cnt != 16'hFFFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 16'h0001;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`else
    assign ovf_cnt = 16'h0000;
`endif

    assign wrreq      = r_wrreq;
    assign wrdata     = r_wrdata;
    assign busy       = r_busy;
    assign burst_done = r_burst_done;
    assign burst_cnt  = r_burst_cnt;

endmodule
`default_nettype wire
